// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and frame sizing for the AES SPI link
package aes_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT_IN, RUN, SHIFT_OUT} link_state_t;

    function automatic int frame_width(input int k);
        return 1 + k + 128;
    endfunction

endpackage

// File: rtl/aes_spi_link_if.sv
// rtl/aes_spi_link_if.sv - SPI pin and AES core signal bundle for the link
interface aes_spi_link_if #(parameter int K = 128);

    logic           sck;
    logic           sdi;
    logic           load;
    logic           sdo;
    logic           done;
    logic           frame_err;
    logic           core_ce;
    logic           core_dir;
    logic [K-1:0]   core_key;
    logic [127:0]   core_message;
    logic           core_done;
    logic [127:0]   core_translated;

    modport master (
        output sck, sdi, load, core_done, core_translated,
        input  sdo, done, frame_err, core_ce, core_dir, core_key, core_message
    );

    modport slave (
        input  sck, sdi, load, core_done, core_translated,
        output sdo, done, frame_err, core_ce, core_dir, core_key, core_message
    );

endinterface

// File: rtl/aes_spi_link_sync_edge.sv
// rtl/aes_spi_link_sync_edge.sv - two-flop synchronizer with edge detect flop
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/aes_spi_link.sv
// rtl/aes_spi_link.sv - SPI responder that frames key/message into the AES core and returns the result
module aes_spi_link
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    aes_spi_link_if.slave  bus
);

    localparam int fw = frame_width(K);
    localparam int cw = $clog2(fw + 2);
    localparam logic [cw-1:0] cnt_full     = cw'(fw);
    localparam logic [cw-1:0] cnt_sat      = cw'(fw + 1);
    localparam logic [cw-1:0] cnt_out_last = cw'(127);

    logic sck_q_unused, sck_rise, sck_fall;
    logic sdi_q, sdi_rise_unused, sdi_fall_unused;
    logic load_q_unused, load_rise, load_fall;

    sync_edge u_sck  (.clk(clk), .reset(reset), .d(bus.sck),  .q(sck_q_unused),  .rise(sck_rise),        .fall(sck_fall));
    sync_edge u_sdi  (.clk(clk), .reset(reset), .d(bus.sdi),  .q(sdi_q),         .rise(sdi_rise_unused), .fall(sdi_fall_unused));
    sync_edge u_load (.clk(clk), .reset(reset), .d(bus.load), .q(load_q_unused), .rise(load_rise),       .fall(load_fall));

    link_state_t      state, state_nx;
    logic [cw-1:0]    cnt;
    logic [fw-1:0]    in_reg;
    logic [127:0]     out_reg;
    logic             sdo_r, done_r, frame_err_r, core_ce_r, core_dir_r;
    logic [K-1:0]     core_key_r;
    logic [127:0]     core_message_r;
    logic             start, latch, capture, shift_in, shift_out;

    // A load rise restarts the link from any state and outranks core_done.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        latch     = 1'b0;
        capture   = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        if (load_rise) begin
            start    = 1'b1;
            state_nx = SHIFT_IN;
        end else begin
            case (state)
                SHIFT_IN: begin
                    if (load_fall) begin
                        latch    = 1'b1;
                        state_nx = RUN;
                    end else if (sck_rise) begin
                        shift_in = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.core_done) begin
                        capture  = 1'b1;
                        state_nx = SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (sck_fall) begin
                        shift_out = 1'b1;
                        if (cnt == cnt_out_last) state_nx = IDLE;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            in_reg         <= '0;
            out_reg        <= '0;
            sdo_r          <= 1'b0;
            done_r         <= 1'b0;
            frame_err_r    <= 1'b0;
            core_ce_r      <= 1'b1;
            core_dir_r     <= 1'b0;
            core_key_r     <= '0;
            core_message_r <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt       <= '0;
                core_ce_r <= 1'b1;
                done_r    <= 1'b0;
                sdo_r     <= 1'b0;
            end
            if (shift_in) begin
                in_reg <= {in_reg[fw-2:0], sdi_q};
                if (cnt != cnt_sat) cnt <= cnt + cw'(1);
            end
            if (latch) begin
                core_dir_r     <= in_reg[fw-1];
                core_key_r     <= in_reg[fw-2:128];
                core_message_r <= in_reg[127:0];
                frame_err_r    <= (cnt != cnt_full);
                core_ce_r      <= 1'b0;
            end
            // The bit counter is reused to count shift-out falls.
            if (capture) begin
                out_reg <= bus.core_translated;
                sdo_r   <= bus.core_translated[127];
                done_r  <= 1'b1;
                cnt     <= '0;
            end
            if (shift_out) begin
                out_reg <= {out_reg[126:0], 1'b0};
                sdo_r   <= out_reg[126];
                cnt     <= cnt + cw'(1);
            end
        end
    end

    assign bus.sdo          = sdo_r;
    assign bus.done         = done_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.core_ce      = core_ce_r;
    assign bus.core_dir     = core_dir_r;
    assign bus.core_key     = core_key_r;
    assign bus.core_message = core_message_r;

endmodule

// File: tb/tb_aes_spi_link.sv
// tb/tb_aes_spi_link.sv - self-checking bench for aes_spi_link with a behavioural core
module tb_aes_spi_link;
    import aes_pkg::*;

    localparam int K  = 128;
    localparam int FW = 1 + K + 128;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_spi_link_if #(.K(K)) bus ();
    aes_spi_link #(.K(K)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    bit auto_core = 1'b1;
    int core_lat = 6;
    int core_cnt = 0;

    function automatic logic [127:0] core_fn(input logic d, input logic [K-1:0] k, input logic [127:0] m);
        if (d == 1'b0 && k == KEY0 && m == PT) return CT;
        if (d == 1'b1 && k == KEY0 && m == CT) return PT;
        return {m[63:0], m[127:64]} ^ k[127:0] ^ {128{d}};
    endfunction

    // Behavioural AES core: result appears core_lat clocks after load is released.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_core) begin
                if (bus.core_ce) begin
                    core_cnt = 0;
                    bus.core_done = 1'b0;
                end else begin
                    core_cnt++;
                    if (core_cnt == core_lat) begin
                        bus.core_translated = core_fn(bus.core_dir, bus.core_key, bus.core_message);
                        bus.core_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_bits(input logic d, input logic [K-1:0] k, input logic [127:0] m, output bit b[$]);
        logic [FW-1:0] f;
        f = {d, k, m};
        b.delete();
        for (int i = FW - 1; i >= 0; i--) b.push_back(f[i]);
    endtask

    task automatic send_bits(input bit b[$]);
        bus.load = 1'b1;
        wclk(4);
        foreach (b[i]) begin
            bus.sdi = b[i];
            wclk(4);
            bus.sck = 1'b1;
            wclk(4);
            bus.sck = 1'b0;
        end
        wclk(4);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            wclk(1);
        end
    endtask

    task automatic read_out(input int n, output logic [127:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = {r[126:0], bus.sdo};
            bus.sck = 1'b1;
            wclk(4);
            bus.sck = 1'b0;
            wclk(4);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wclk(4);
        total++; if (bus.sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got=%b exp=0", bus.sdo); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", bus.frame_err); end
        total++; if (bus.core_ce !== 1'b1) begin bad++; $display("FAIL rst_ce got=%b exp=1", bus.core_ce); end
        total++; if ({bus.core_dir, bus.core_key, bus.core_message} !== '0) begin bad++; $display("FAIL rst_core got=%h exp=0", {bus.core_dir, bus.core_key, bus.core_message}); end
        reset = 1'b1;
        wclk(2);
    endtask

    task automatic test_encrypt;
        bit b[$];
        bit ok;
        logic [127:0] r;
        frame_bits(1'b0, KEY0, PT, b);
        send_bits(b);
        bus.load = 1'b0;
        wclk(2);
        total++; if (bus.core_ce !== 1'b1) begin bad++; $display("FAIL enc_ce_early got=%b exp=1", bus.core_ce); end
        wclk(1);
        total++; if (bus.core_ce !== 1'b0) begin bad++; $display("FAIL enc_ce_fall got=%b exp=0", bus.core_ce); end
        total++; if (bus.core_key !== KEY0 || bus.core_message !== PT || bus.core_dir !== 1'b0) begin bad++; $display("FAIL enc_core got=%b %h %h exp=0 %h %h", bus.core_dir, bus.core_key, bus.core_message, KEY0, PT); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL enc_done_timeout got=0 exp=1"); end
        read_out(128, r);
        total++; if (r !== CT) begin bad++; $display("FAIL enc_result got=%h exp=%h", r, CT); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL enc_ferr got=%b exp=0", bus.frame_err); end
        wclk(8);
        total++; if (bus.sdo !== 1'b0 || bus.done !== 1'b1) begin bad++; $display("FAIL enc_tail got=%b%b exp=01", bus.sdo, bus.done); end
    endtask

    task automatic test_decrypt;
        bit b[$];
        bit ok;
        logic [127:0] r;
        frame_bits(1'b1, KEY0, CT, b);
        send_bits(b);
        bus.load = 1'b0;
        wclk(4);
        total++; if (bus.core_dir !== 1'b1) begin bad++; $display("FAIL dec_dir got=%b exp=1", bus.core_dir); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL dec_done_timeout got=0 exp=1"); end
        read_out(128, r);
        total++; if (r !== PT) begin bad++; $display("FAIL dec_result got=%h exp=%h", r, PT); end
    endtask

    task automatic test_frame_len;
        bit b[$];
        logic [FW-1:0] exp_f;
        b.delete();
        for (int i = 0; i < 200; i++) b.push_back(1'($urandom));
        send_bits(b);
        bus.load = 1'b0;
        wclk(4);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL short_ferr got=%b exp=1", bus.frame_err); end
        b.delete();
        for (int i = 0; i < FW + 5; i++) b.push_back(1'($urandom));
        for (int i = 0; i < FW; i++) exp_f[FW-1-i] = b[5 + i];
        send_bits(b);
        bus.load = 1'b0;
        wclk(4);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL long_ferr got=%b exp=1", bus.frame_err); end
        total++; if ({bus.core_dir, bus.core_key, bus.core_message} !== exp_f) begin bad++; $display("FAIL long_frame got=%h exp=%h", {bus.core_dir, bus.core_key, bus.core_message}, exp_f); end
        wclk(20);
    endtask

    task automatic test_abort;
        bit b[$];
        bit ok;
        logic [127:0] r;
        core_lat = 30;
        frame_bits(1'b0, KEY0, PT, b);
        send_bits(b);
        bus.load = 1'b0;
        wclk(13);
        total++; if (bus.core_ce !== 1'b0) begin bad++; $display("FAIL abort_run_ce got=%b exp=0", bus.core_ce); end
        bus.load = 1'b1;
        wclk(3);
        total++; if (bus.core_ce !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL abort_restart got=%b%b exp=10", bus.core_ce, bus.done); end
        core_lat = 6;
        send_bits(b);
        bus.load = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_done_timeout got=0 exp=1"); end
        read_out(128, r);
        total++; if (r !== CT) begin bad++; $display("FAIL abort_result got=%h exp=%h", r, CT); end
    endtask

    task automatic test_reset_mid;
        bit b[$];
        bit ok;
        logic [127:0] r;
        frame_bits(1'b0, KEY0, PT, b);
        send_bits(b);
        bus.load = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_done_timeout got=0 exp=1"); end
        read_out(40, r);
        total++; if (r[39:0] !== CT[127:88]) begin bad++; $display("FAIL rmid_partial got=%h exp=%h", r[39:0], CT[127:88]); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.sdo !== 1'b0 || bus.done !== 1'b0 || bus.core_ce !== 1'b1) begin bad++; $display("FAIL rmid_reset got=%b%b%b exp=001", bus.sdo, bus.done, bus.core_ce); end
        @(negedge clk);
        reset = 1'b1;
        wclk(2);
        for (int i = 0; i < 10; i++) begin
            bus.sdi = 1'($urandom);
            bus.sck = 1'b1;
            wclk(4);
            bus.sck = 1'b0;
            wclk(4);
        end
        total++; if (bus.sdo !== 1'b0 || bus.done !== 1'b0 || bus.core_ce !== 1'b1 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL rmid_idle_sck got=%b%b%b%b exp=0010", bus.sdo, bus.done, bus.core_ce, bus.frame_err); end
    endtask

    task automatic test_done_collide;
        bit b[$];
        auto_core = 1'b0;
        bus.core_done = 1'b0;
        frame_bits(1'b0, KEY0, PT, b);
        send_bits(b);
        bus.load = 1'b0;
        wclk(10);
        bus.load = 1'b1;
        wclk(2);
        bus.core_done = 1'b1;
        bus.core_translated = {$urandom, $urandom, $urandom, $urandom};
        wclk(1);
        total++; if (dut.state !== SHIFT_IN) begin bad++; $display("FAIL coll_state got=%0d exp=%0d", dut.state, SHIFT_IN); end
        total++; if (bus.done !== 1'b0 || bus.core_ce !== 1'b1) begin bad++; $display("FAIL coll_flags got=%b%b exp=01", bus.done, bus.core_ce); end
        wclk(5);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL coll_done_hold got=%b exp=0", bus.done); end
        bus.core_done = 1'b0;
        auto_core = 1'b1;
        bus.load = 1'b0;
        wclk(20);
    endtask

    task automatic test_random;
        bit b[$];
        bit ok;
        logic d;
        logic [K-1:0] k;
        logic [127:0] m, r, exp_r;
        for (int n = 0; n < 3; n++) begin
            d = 1'($urandom);
            k = {$urandom, $urandom, $urandom, $urandom};
            m = {$urandom, $urandom, $urandom, $urandom};
            exp_r = core_fn(d, k, m);
            frame_bits(d, k, m, b);
            send_bits(b);
            bus.load = 1'b0;
            wclk(4);
            total++; if (bus.core_dir !== d || bus.core_key !== k || bus.core_message !== m) begin bad++; $display("FAIL rnd%0d_core got=%b %h %h exp=%b %h %h", n, bus.core_dir, bus.core_key, bus.core_message, d, k, m); end
            wait_done(ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done_timeout got=0 exp=1", n); end
            read_out(128, r);
            total++; if (r !== exp_r) begin bad++; $display("FAIL rnd%0d_result got=%h exp=%h", n, r, exp_r); end
        end
    endtask

    initial begin
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.load = 1'b0;
        bus.core_done = 1'b0;
        bus.core_translated = '0;
        test_reset;
        test_encrypt;
        test_decrypt;
        test_frame_len;
        test_abort;
        test_reset_mid;
        test_done_collide;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
